// File: rtl/mycpu_pkg.sv
// rtl/mycpu_pkg.sv - shared bus widths, ld_op bit indices and MEM slot state encoding
package mycpu_pkg;

  localparam int EX_MEM_W = 213;
  localparam int MEM_WB_W = 207;
  localparam int FWD_W    = 39;

  localparam int LD_B  = 4;
  localparam int LD_BU = 3;
  localparam int LD_H  = 2;
  localparam int LD_HU = 1;
  localparam int LD_W  = 0;

  // EX_to_MEM_bus = {ld_op[4:0], req_sent, wb_fields[206:0]}
  localparam int LD_OP_LSB    = 208;
  localparam int REQ_SENT_BIT = 207;

  // wb_fields positions that the forwarding bus taps
  localparam int WB_GR_WE_BIT = 38;
  localparam int WB_DEST_LSB  = 33;

  typedef enum logic [1:0] {
    MEM_EMPTY = 2'd0,
    MEM_WAIT  = 2'd1,
    MEM_READY = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_load_ext.sv
// rtl/mem_load_ext.sv - byte/half/word select and sign/zero extension of load data
module mem_load_ext
  import mycpu_pkg::*;
(
  input  logic [4:0]  ld_op_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    data_o = rdata_i;
    if (ld_op_i[LD_B])       data_o = {{24{byte_sel[7]}}, byte_sel};
    else if (ld_op_i[LD_BU]) data_o = {24'd0, byte_sel};
    else if (ld_op_i[LD_H])  data_o = {{16{half_sel[15]}}, half_sel};
    else if (ld_op_i[LD_HU]) data_o = {16'd0, half_sel};
    else if (ld_op_i[LD_W])  data_o = rdata_i;
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage with load wait/cancel; MEM_LOAD_BUF_EN adds ld_buf for WB stalls
module mem_stage
  import mycpu_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                EX_to_MEM_valid,
  input  logic [EX_MEM_W-1:0] EX_to_MEM_bus,
  output logic                MEM_allowin,
  input  logic                WB_allowin,
  output logic                MEM_to_WB_valid,
  output logic [MEM_WB_W-1:0] MEM_to_WB_bus,
  output logic                out_MEM_valid,
  output logic [FWD_W-1:0]    MEM_fwd_bus,
  input  logic                exec_flush,
  input  logic                data_sram_req,
  input  logic                data_sram_addr_ok,
  input  logic                data_sram_data_ok,
  input  logic [31:0]         data_sram_rdata
);

  mem_state_e          state_q, state_d;
  logic [MEM_WB_W-1:0] fields_q;
  logic [4:0]          ld_op_q;
  logic                req_sent_q;
  logic [CNT_W-1:0]    outstanding_q, outstanding_d;
  logic [CNT_W-1:0]    cancel_q, cancel_d;

  logic [4:0]  in_ld_op;
  logic        in_req_sent;
  logic        mem_valid, is_load, data_ok_acc, ready_go, handover, req_acc;
  logic [31:0] ld_raw, ld_ext, wdata;

  assign in_ld_op    = EX_to_MEM_bus[LD_OP_LSB +: 5];
  assign in_req_sent = EX_to_MEM_bus[REQ_SENT_BIT];

  assign mem_valid   = (state_q != MEM_EMPTY);
  assign is_load     = (|ld_op_q) & req_sent_q;
  assign req_acc     = data_sram_req & data_sram_addr_ok;
  // Responses are discarded while earlier killed requests are still draining.
  assign data_ok_acc = data_sram_data_ok & (cancel_q == '0);
  assign ready_go    = (state_q == MEM_READY) | ((state_q == MEM_WAIT) & data_ok_acc);

  assign MEM_allowin     = !mem_valid | (ready_go & WB_allowin);
  assign MEM_to_WB_valid = mem_valid & ready_go & !exec_flush;
  assign handover        = MEM_allowin & EX_to_MEM_valid & !exec_flush;

  always_comb begin
    outstanding_d = outstanding_q;
    if (req_acc & !data_sram_data_ok)      outstanding_d = outstanding_q + CNT_W'(1);
    else if (!req_acc & data_sram_data_ok) outstanding_d = outstanding_q - CNT_W'(1);

    cancel_d = cancel_q;
    if (exec_flush)                                cancel_d = outstanding_d;
    else if (data_sram_data_ok & (cancel_q != '0)) cancel_d = cancel_q - CNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    if (exec_flush)       state_d = MEM_EMPTY;
    else if (handover)    state_d = ((|in_ld_op) & in_req_sent) ? MEM_WAIT : MEM_READY;
    else if (MEM_allowin) state_d = MEM_EMPTY;
`ifdef MEM_LOAD_BUF_EN
    else if ((state_q == MEM_WAIT) & data_ok_acc) state_d = MEM_READY;
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= MEM_EMPTY;
      fields_q      <= '0;
      ld_op_q       <= '0;
      req_sent_q    <= 1'b0;
      outstanding_q <= '0;
      cancel_q      <= '0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      cancel_q      <= cancel_d;
      if (handover) begin
        fields_q   <= EX_to_MEM_bus[MEM_WB_W-1:0];
        ld_op_q    <= in_ld_op;
        req_sent_q <= in_req_sent;
      end
    end
  end

`ifdef MEM_LOAD_BUF_EN
  logic [31:0] ld_buf_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ld_buf_q <= '0;
    end else if ((state_q == MEM_WAIT) & data_ok_acc) begin
      ld_buf_q <= data_sram_rdata;
    end
  end

  assign ld_raw = (state_q == MEM_WAIT) ? data_sram_rdata : ld_buf_q;
`else
  assign ld_raw = data_sram_rdata;

  // Without ld_buf a returning load must leave in its data_ok cycle.
  assert property (@(posedge clk) disable iff (!resetn)
    !((state_q == MEM_WAIT) && data_ok_acc && !WB_allowin));
`endif

  mem_load_ext u_load_ext (
    .ld_op_i (ld_op_q),
    .addr_i  (fields_q[1:0]),
    .rdata_i (ld_raw),
    .data_o  (ld_ext)
  );

  assign wdata         = is_load ? ld_ext : fields_q[31:0];
  assign MEM_to_WB_bus = {fields_q[MEM_WB_W-1:32], wdata};
  assign out_MEM_valid = mem_valid;
  assign MEM_fwd_bus   = {mem_valid & fields_q[WB_GR_WE_BIT], fields_q[WB_DEST_LSB +: 5],
                          wdata, mem_valid & (state_q == MEM_WAIT)};

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized self-checking bench for mem_stage against a behavioural model
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         resetn;
  logic         EX_to_MEM_valid;
  logic [212:0] EX_to_MEM_bus;
  logic         MEM_allowin;
  logic         WB_allowin;
  logic         MEM_to_WB_valid;
  logic [206:0] MEM_to_WB_bus;
  logic         out_MEM_valid;
  logic [38:0]  MEM_fwd_bus;
  logic         exec_flush;
  logic         data_sram_req;
  logic         data_sram_addr_ok;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .EX_to_MEM_valid   (EX_to_MEM_valid),
    .EX_to_MEM_bus     (EX_to_MEM_bus),
    .MEM_allowin       (MEM_allowin),
    .WB_allowin        (WB_allowin),
    .MEM_to_WB_valid   (MEM_to_WB_valid),
    .MEM_to_WB_bus     (MEM_to_WB_bus),
    .out_MEM_valid     (out_MEM_valid),
    .MEM_fwd_bus       (MEM_fwd_bus),
    .exec_flush        (exec_flush),
    .data_sram_req     (data_sram_req),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata)
  );

  function automatic logic [206:0] rand_fields();
    logic [223:0] f;
    for (int k = 0; k < 7; k++) f[k*32 +: 32] = $urandom;
    return f[206:0];
  endfunction

  // op: 4=ld_b 3=ld_bu 2=ld_h 1=ld_hu 0=ld_w
  function automatic logic [31:0] ref_ext(input int op, input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * addr[1:0])) & 32'hFF;
    h = (rd >> (16 * addr[1])) & 32'hFFFF;
    case (op)
      4:       return (b >= 32'd128) ? b - 32'd256 : b;
      3:       return b;
      2:       return (h >= 32'h8000) ? h - 32'h10000 : h;
      1:       return h;
      default: return rd;
    endcase
  endfunction

  task automatic idle_inputs();
    EX_to_MEM_valid   = 1'b0;
    EX_to_MEM_bus     = '0;
    WB_allowin        = 1'b1;
    exec_flush        = 1'b0;
    data_sram_req     = 1'b0;
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (MEM_allowin !== 1'b1) begin failures++; $display("FAIL reset_allowin got=%b exp=1", MEM_allowin); end
    checks++; if (MEM_to_WB_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%b exp=0", MEM_to_WB_valid); end
    checks++; if (out_MEM_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_valid got=%b exp=0", out_MEM_valid); end
    checks++; if (MEM_fwd_bus !== 39'd0) begin failures++; $display("FAIL reset_fwd got=%h exp=0", MEM_fwd_bus); end
    checks++; if (MEM_to_WB_bus !== 207'd0) begin failures++; $display("FAIL reset_wb_bus got=%h exp=0", MEM_to_WB_bus); end
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic test_alu();
    logic [206:0] fl;
    fl = rand_fields();
    fl[38] = 1'b1; fl[37:33] = 5'd4; fl[31:0] = 32'h55;
    EX_to_MEM_valid = 1'b1; EX_to_MEM_bus = {5'd0, 1'b0, fl};
    @(negedge clk);
    checks++; if (MEM_to_WB_valid !== 1'b0) begin failures++; $display("FAIL alu_handover_cycle got=%b exp=0", MEM_to_WB_valid); end
    @(posedge clk); #1;
    EX_to_MEM_valid = 1'b0;
    @(negedge clk);
    checks++; if (MEM_to_WB_valid !== 1'b1) begin failures++; $display("FAIL alu_valid got=%b exp=1", MEM_to_WB_valid); end
    checks++; if (MEM_fwd_bus !== {1'b1, 5'd4, 32'h55, 1'b0}) begin failures++; $display("FAIL alu_fwd got=%h exp=%h", MEM_fwd_bus, {1'b1, 5'd4, 32'h55, 1'b0}); end
    checks++; if (MEM_to_WB_bus !== fl) begin failures++; $display("FAIL alu_bus got=%h exp=%h", MEM_to_WB_bus, fl); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (out_MEM_valid !== 1'b0) begin failures++; $display("FAIL alu_drain got=%b exp=0", out_MEM_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic         m_valid, acc, ev, wa;
    logic [206:0] m_fields, nf;
    m_valid = 1'b0; m_fields = '0;
    for (int c = 0; c < 40; c++) begin
      nf = rand_fields();
      ev = ($urandom_range(0, 3) != 0);
      wa = ($urandom_range(0, 3) != 0);
      EX_to_MEM_valid = ev; EX_to_MEM_bus = {5'd0, 1'b0, nf}; WB_allowin = wa;
      @(negedge clk);
      checks++; if (MEM_to_WB_valid !== m_valid) begin failures++; $display("FAIL b2b_valid c=%0d got=%b exp=%b", c, MEM_to_WB_valid, m_valid); end
      checks++; if (MEM_allowin !== (!m_valid || wa)) begin failures++; $display("FAIL b2b_allowin c=%0d got=%b exp=%b", c, MEM_allowin, (!m_valid || wa)); end
      if (m_valid) begin
        checks++; if (MEM_to_WB_bus !== m_fields) begin failures++; $display("FAIL b2b_bus c=%0d got=%h exp=%h", c, MEM_to_WB_bus, m_fields); end
        checks++; if (MEM_fwd_bus !== {m_fields[38], m_fields[37:33], m_fields[31:0], 1'b0}) begin failures++; $display("FAIL b2b_fwd c=%0d got=%h exp=%h", c, MEM_fwd_bus, {m_fields[38], m_fields[37:33], m_fields[31:0], 1'b0}); end
      end
      @(posedge clk); #1;
      acc = (!m_valid || wa) && ev;
      if (m_valid && wa) m_valid = 1'b0;
      if (acc) begin m_valid = 1'b1; m_fields = nf; end
    end
    idle_inputs();
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_loads();
    int           op[14];
    int           wt[14];
    logic [31:0]  ad[14];
    logic [31:0]  rd[14];
    logic [206:0] fl[14];
    logic [31:0]  exp_d;
    op[0] = 0; ad[0] = 32'h1000; rd[0] = 32'h8000_00F0; wt[0] = 2;
    op[1] = 4; ad[1] = 32'h1003; rd[1] = 32'h80AA_BBCC; wt[1] = 0;
    op[2] = 3; ad[2] = 32'h1003; rd[2] = 32'h80AA_BBCC; wt[2] = 1;
    op[3] = 2; ad[3] = 32'h1000; rd[3] = 32'h0000_8001; wt[3] = 0;
    for (int i = 4; i < 14; i++) begin
      op[i] = $urandom_range(0, 4);
      ad[i] = $urandom;
      if (op[i] == 0) ad[i][1:0] = 2'b00;
      if (op[i] == 1 || op[i] == 2) ad[i][0] = 1'b0;
      rd[i] = $urandom;
      wt[i] = $urandom_range(0, 3);
    end
    for (int i = 0; i < 14; i++) begin
      fl[i] = rand_fields();
      fl[i][31:0] = ad[i];
    end
    EX_to_MEM_valid = 1'b1; EX_to_MEM_bus = {5'd1 << op[0], 1'b1, fl[0]};
    data_sram_req = 1'b1; data_sram_addr_ok = 1'b1;
    @(negedge clk);
    checks++; if (MEM_allowin !== 1'b1) begin failures++; $display("FAIL ld_first_allowin got=%b exp=1", MEM_allowin); end
    @(posedge clk); #1;
    for (int i = 0; i < 14; i++) begin
      EX_to_MEM_valid = 1'b0; data_sram_req = 1'b0; data_sram_addr_ok = 1'b0;
      data_sram_data_ok = 1'b0;
      for (int w = 0; w < wt[i]; w++) begin
        @(negedge clk);
        checks++; if (MEM_fwd_bus[0] !== 1'b1) begin failures++; $display("FAIL ld_pending i=%0d got=%b exp=1", i, MEM_fwd_bus[0]); end
        checks++; if (MEM_to_WB_valid !== 1'b0) begin failures++; $display("FAIL ld_early_valid i=%0d got=%b exp=0", i, MEM_to_WB_valid); end
        checks++; if (MEM_allowin !== 1'b0) begin failures++; $display("FAIL ld_wait_allowin i=%0d got=%b exp=0", i, MEM_allowin); end
        @(posedge clk); #1;
      end
      data_sram_data_ok = 1'b1; data_sram_rdata = rd[i];
      if (i < 13) begin
        EX_to_MEM_valid = 1'b1; EX_to_MEM_bus = {5'd1 << op[i+1], 1'b1, fl[i+1]};
        data_sram_req = 1'b1; data_sram_addr_ok = 1'b1;
      end
      exp_d = ref_ext(op[i], ad[i], rd[i]);
      @(negedge clk);
      checks++; if (MEM_to_WB_valid !== 1'b1) begin failures++; $display("FAIL ld_valid i=%0d got=%b exp=1", i, MEM_to_WB_valid); end
      checks++; if (MEM_to_WB_bus !== {fl[i][206:32], exp_d}) begin failures++; $display("FAIL ld_data i=%0d op=%0d got=%h exp=%h", i, op[i], MEM_to_WB_bus[31:0], exp_d); end
      checks++; if (MEM_fwd_bus[32:1] !== exp_d) begin failures++; $display("FAIL ld_fwd_data i=%0d got=%h exp=%h", i, MEM_fwd_bus[32:1], exp_d); end
      checks++; if (MEM_allowin !== 1'b1) begin failures++; $display("FAIL ld_done_allowin i=%0d got=%b exp=1", i, MEM_allowin); end
      @(posedge clk); #1;
    end
    idle_inputs();
    @(negedge clk);
    checks++; if (out_MEM_valid !== 1'b0) begin failures++; $display("FAIL ld_drain got=%b exp=0", out_MEM_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_misaligned();
    logic [206:0] fl;
    logic [4:0]   ops[2];
    ops[0] = 5'b00001; ops[1] = 5'b00100;
    for (int k = 0; k < 2; k++) begin
      fl = rand_fields();
      fl[1:0] = (k == 0) ? 2'b10 : 2'b01;
      EX_to_MEM_valid = 1'b1; EX_to_MEM_bus = {ops[k], 1'b0, fl};
      @(posedge clk); #1;
      EX_to_MEM_valid = 1'b0;
      @(negedge clk);
      checks++; if (MEM_to_WB_valid !== 1'b1) begin failures++; $display("FAIL misal_valid k=%0d got=%b exp=1", k, MEM_to_WB_valid); end
      checks++; if (MEM_to_WB_bus !== fl) begin failures++; $display("FAIL misal_bus k=%0d got=%h exp=%h", k, MEM_to_WB_bus, fl); end
      checks++; if (MEM_fwd_bus[0] !== 1'b0) begin failures++; $display("FAIL misal_pending k=%0d got=%b exp=0", k, MEM_fwd_bus[0]); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if (out_MEM_valid !== 1'b0) begin failures++; $display("FAIL misal_drain got=%b exp=0", out_MEM_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    logic [206:0] f1, f2, fa;
    logic [31:0]  rx, ry;
    f1 = rand_fields(); f1[31:0] = 32'h3000;
    f2 = rand_fields(); f2[31:0] = 32'h3002;
    fa = rand_fields();
    rx = $urandom; ry = $urandom;
    EX_to_MEM_valid = 1'b1; EX_to_MEM_bus = {5'b00001, 1'b1, f1};
    data_sram_req = 1'b1; data_sram_addr_ok = 1'b1;
    @(posedge clk); #1;
    EX_to_MEM_valid = 1'b0; data_sram_req = 1'b0; data_sram_addr_ok = 1'b0;
    exec_flush = 1'b1;
    @(negedge clk);
    checks++; if (MEM_to_WB_valid !== 1'b0) begin failures++; $display("FAIL flush_wb_valid got=%b exp=0", MEM_to_WB_valid); end
    @(posedge clk); #1;
    EX_to_MEM_valid = 1'b1; EX_to_MEM_bus = {5'd0, 1'b0, fa};
    @(negedge clk);
    checks++; if (out_MEM_valid !== 1'b0) begin failures++; $display("FAIL flush_mem_valid got=%b exp=0", out_MEM_valid); end
    @(posedge clk); #1;
    exec_flush = 1'b0;
    EX_to_MEM_bus = {5'b00010, 1'b1, f2};
    data_sram_req = 1'b1; data_sram_addr_ok = 1'b1;
    @(negedge clk);
    checks++; if (out_MEM_valid !== 1'b0) begin failures++; $display("FAIL flush_ex_latched got=%b exp=0", out_MEM_valid); end
    @(posedge clk); #1;
    EX_to_MEM_valid = 1'b0; data_sram_req = 1'b0; data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b1; data_sram_rdata = rx;
    @(negedge clk);
    checks++; if (MEM_to_WB_valid !== 1'b0) begin failures++; $display("FAIL flush_stale_dropped got=%b exp=0", MEM_to_WB_valid); end
    checks++; if (MEM_fwd_bus[0] !== 1'b1) begin failures++; $display("FAIL flush_still_pending got=%b exp=1", MEM_fwd_bus[0]); end
    @(posedge clk); #1;
    data_sram_rdata = ry;
    @(negedge clk);
    checks++; if (MEM_to_WB_valid !== 1'b1) begin failures++; $display("FAIL flush_next_valid got=%b exp=1", MEM_to_WB_valid); end
    checks++; if (MEM_to_WB_bus[31:0] !== ref_ext(1, 32'h3002, ry)) begin failures++; $display("FAIL flush_next_data got=%h exp=%h", MEM_to_WB_bus[31:0], ref_ext(1, 32'h3002, ry)); end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    checks++; if (out_MEM_valid !== 1'b0) begin failures++; $display("FAIL flush_drain got=%b exp=0", out_MEM_valid); end
    @(posedge clk); #1;
  endtask

`ifdef MEM_LOAD_BUF_EN
  task automatic test_load_buf();
    logic [206:0] fl;
    fl = rand_fields(); fl[31:0] = 32'h2000;
    EX_to_MEM_valid = 1'b1; EX_to_MEM_bus = {5'b00001, 1'b1, fl};
    data_sram_req = 1'b1; data_sram_addr_ok = 1'b1;
    @(posedge clk); #1;
    EX_to_MEM_valid = 1'b0; data_sram_req = 1'b0; data_sram_addr_ok = 1'b0;
    @(posedge clk); #1;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1234; WB_allowin = 1'b0;
    @(negedge clk);
    checks++; if (MEM_allowin !== 1'b0) begin failures++; $display("FAIL buf_dok_allowin got=%b exp=0", MEM_allowin); end
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0; data_sram_rdata = $urandom;
    @(negedge clk);
    checks++; if (MEM_to_WB_valid !== 1'b1) begin failures++; $display("FAIL buf_held_valid got=%b exp=1", MEM_to_WB_valid); end
    checks++; if (MEM_to_WB_bus[31:0] !== 32'h1234) begin failures++; $display("FAIL buf_held_data got=%h exp=00001234", MEM_to_WB_bus[31:0]); end
    checks++; if (MEM_allowin !== 1'b0) begin failures++; $display("FAIL buf_held_allowin got=%b exp=0", MEM_allowin); end
    @(posedge clk); #1;
    WB_allowin = 1'b1;
    @(negedge clk);
    checks++; if (MEM_to_WB_bus[31:0] !== 32'h1234) begin failures++; $display("FAIL buf_release_data got=%h exp=00001234", MEM_to_WB_bus[31:0]); end
    checks++; if (MEM_allowin !== 1'b1) begin failures++; $display("FAIL buf_release_allowin got=%b exp=1", MEM_allowin); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (out_MEM_valid !== 1'b0) begin failures++; $display("FAIL buf_drain got=%b exp=0", out_MEM_valid); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_loads();
    test_misaligned();
    test_flush();
`ifdef MEM_LOAD_BUF_EN
    test_load_buf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
